// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 pad byte and the 64-bit bit length, and adds an extra block when needed.
module sha256_msg_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    EMIT_EXTRA = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [0:15][31:0] buf_r;
  logic [3:0]        w_r;
  logic [63:0]       len_r;
  logic              extra_r;
  logic              extra_pad_r;
  logic              start_r;
  logic              in_ready_r;
  logic              blk_valid_r;
  logic              blk_first_r;
  logic              blk_last_r;

  logic              in_fire_s;
  logic              blk_fire_s;
  logic              blk_done_s;
  logic [2:0]        nbytes_s;
  logic [4:0]        pad_idx_s;
  logic [63:0]       len_next_s;
  logic [31:0]       last_word_s;

  assign in_ready  = in_ready_r;
  assign blk_valid = blk_valid_r;
  assign blk_data  = buf_r;
  assign blk_first = blk_first_r;
  assign blk_last  = blk_last_r;

  // Handshakes, final-word byte count, pad position and masked final word
  always_comb begin
    in_fire_s  = in_valid && in_ready_r;
    blk_fire_s = blk_valid_r && blk_ready;
    nbytes_s   = (in_nbytes == 2'd0) ? 3'd4 : {1'b0, in_nbytes};
    pad_idx_s  = {1'b0, w_r} + ((nbytes_s == 3'd4) ? 5'd1 : 5'd0);
    len_next_s = len_r + (in_last ? {58'd0, nbytes_s, 3'd0} : 64'd32);
    blk_done_s = in_fire_s && (in_last || (w_r == 4'd15));
    case (in_nbytes)
      2'd1:    last_word_s = {in_data[31:24], 8'h80, 16'h0000};
      2'd2:    last_word_s = {in_data[31:16], 8'h80, 8'h00};
      2'd3:    last_word_s = {in_data[31:8], 8'h80};
      default: last_word_s = in_data;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (blk_done_s) state_s = EMIT;
        else            state_s = FILL;
      end
      EMIT: begin
        if (blk_fire_s) state_s = extra_r ? EMIT_EXTRA : FILL;
        else            state_s = EMIT;
      end
      EMIT_EXTRA: begin
        if (blk_fire_s) state_s = FILL;
        else            state_s = EMIT_EXTRA;
      end
      default: state_s = FILL;
    endcase
  end

  // State register with registered handshake outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      in_ready_r  <= 1'b0;
      blk_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == FILL);
      blk_valid_r <= (state_s != FILL);
    end
  end

  // Block buffer, word index, length counter and block flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r       <= 512'd0;
      w_r         <= 4'd0;
      len_r       <= 64'd0;
      extra_r     <= 1'b0;
      extra_pad_r <= 1'b0;
      start_r     <= 1'b1;
      blk_first_r <= 1'b0;
      blk_last_r  <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (in_fire_s) begin
            len_r <= len_next_s;
            w_r   <= in_last ? 4'd0 : (w_r + 4'd1);
            if (in_last) begin
              // The buffer is zeroed after every block, so only pad and length need writing
              buf_r[w_r] <= last_word_s;
              if ((nbytes_s == 3'd4) && (w_r != 4'd15)) buf_r[w_r + 4'd1] <= 32'h8000_0000;
              if (pad_idx_s <= 5'd13) begin
                buf_r[4'd14] <= len_next_s[63:32];
                buf_r[4'd15] <= len_next_s[31:0];
              end
              extra_r     <= (pad_idx_s >= 5'd14);
              extra_pad_r <= (pad_idx_s == 5'd16);
              blk_last_r  <= (pad_idx_s <= 5'd13);
            end else begin
              buf_r[w_r] <= in_data;
              extra_r    <= 1'b0;
              blk_last_r <= 1'b0;
            end
            if (blk_done_s) begin
              blk_first_r <= start_r;
              start_r     <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (blk_fire_s) begin
            if (extra_r) begin
              buf_r       <= {(extra_pad_r ? 32'h8000_0000 : 32'h0000_0000), 416'd0, len_r};
              blk_first_r <= 1'b0;
              blk_last_r  <= 1'b1;
              extra_r     <= 1'b0;
            end else begin
              buf_r <= 512'd0;
              if (blk_last_r) begin
                start_r <= 1'b1;
                len_r   <= 64'd0;
              end
            end
          end
        end
        EMIT_EXTRA: begin
          if (blk_fire_s) begin
            buf_r   <= 512'd0;
            start_r <= 1'b1;
            len_r   <= 64'd0;
          end
        end
        default: begin
          buf_r <= 512'd0;
          w_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed block words plus a
// byte-level padding reference for the multi-word messages.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = 32'd0;
  logic         in_last = 1'b0;
  logic [1:0]   in_nbytes = 2'd0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int compared = 0;
  int mismatched = 0;

  logic [511:0] exp_blk [2];
  int           exp_n;
  logic [511:0] gd;
  logic         gf, gl;
  logic [511:0] hd;
  logic         hf, hl;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] A_BLK   = {32'h61800000, 448'd0, 32'h00000008};

  sha256_msg_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [511:0] b, input int i);
    return b[511 - 32*i -: 32];
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: message bytes are i[7:0], then 0x80, zeros, 64-bit bit length
  task automatic build_model(input int len);
    logic [7:0]  pb [128];
    logic [63:0] lb;
    lb    = 64'(len) * 64'd8;
    exp_n = (len + 8) / 64 + 1;
    for (int i = 0; i < 128; i++)
      pb[i] = (i < len) ? i[7:0] : ((i == len) ? 8'h80 : 8'h00);
    for (int k = 0; k < 8; k++)
      pb[64*exp_n - 8 + k] = lb[63 - 8*k -: 8];
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 64; i++)
        exp_blk[j][511 - 8*i -: 8] = pb[64*j + i];
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int cnt;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bytes beyond the message end are driven as 0xEE to check they are ignored
  task automatic send_msg(input int len);
    int nw;
    logic [31:0] d;
    int idx;
    nw = (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4*k + b;
        d[31 - 8*b -: 8] = (idx < len) ? idx[7:0] : 8'hEE;
      end
      send_word(d, (k == nw - 1), 2'(len % 4));
    end
  endtask

  task automatic get_blk(output logic [511:0] d, output logic f, output logic l);
    int cnt;
    cnt = 0;
    while (blk_valid !== 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("blk_valid_wait", blk_valid, 1'b1);
    d = blk_data;
    f = blk_first;
    l = blk_last;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_blk_data", blk_data, 512'd0);
    chk("rst_blk_first", blk_first, 1'b0);
    chk("rst_blk_last", blk_last, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_release", in_ready, 1'b1);

    // "abc"
    send_word(32'h61626300, 1'b1, 2'd3);
    chk("abc_valid_latency", blk_valid, 1'b1);
    chk("abc_ready_low", in_ready, 1'b0);
    get_blk(gd, gf, gl);
    chk("abc_data", gd, ABC_BLK);
    chk("abc_first", gf, 1'b1);
    chk("abc_last", gl, 1'b1);
    chk("abc_ready_after", in_ready, 1'b1);

    // 6 bytes, last word with 2 valid bytes and junk low bytes
    send_word(32'h00010203, 1'b0, 2'd0);
    send_word(32'h0405AAAA, 1'b1, 2'd2);
    get_blk(gd, gf, gl);
    chk("b6_data", gd, {32'h00010203, 32'h04058000, 416'd0, 32'h00000030});
    chk("b6_first", gf, 1'b1);
    chk("b6_last", gl, 1'b1);

    // 55 bytes: pad fits in word 13, single block
    build_model(55);
    send_msg(55);
    get_blk(gd, gf, gl);
    chk("b55_w13", word_of(gd, 13), 32'h34353680);
    chk("b55_w14", word_of(gd, 14), 32'h00000000);
    chk("b55_w15", word_of(gd, 15), 32'h000001B8);
    chk("b55_model", gd, exp_blk[0]);
    chk("b55_first", gf, 1'b1);
    chk("b55_last", gl, 1'b1);

    // 56 bytes: pad lands in word 14, length spills to an extra block
    build_model(56);
    send_msg(56);
    get_blk(gd, gf, gl);
    chk("b56_1_w13", word_of(gd, 13), 32'h34353637);
    chk("b56_1_w14", word_of(gd, 14), 32'h80000000);
    chk("b56_1_w15", word_of(gd, 15), 32'h00000000);
    chk("b56_1_model", gd, exp_blk[0]);
    chk("b56_1_first", gf, 1'b1);
    chk("b56_1_last", gl, 1'b0);
    get_blk(gd, gf, gl);
    chk("b56_2_data", gd, {480'd0, 32'h000001C0});
    chk("b56_2_model", gd, exp_blk[1]);
    chk("b56_2_first", gf, 1'b0);
    chk("b56_2_last", gl, 1'b1);

    // 64 bytes: full data block, then pad+length block
    build_model(64);
    send_msg(64);
    get_blk(gd, gf, gl);
    chk("b64_1_w15", word_of(gd, 15), 32'h3C3D3E3F);
    chk("b64_1_model", gd, exp_blk[0]);
    chk("b64_1_first", gf, 1'b1);
    chk("b64_1_last", gl, 1'b0);
    get_blk(gd, gf, gl);
    chk("b64_2_w0", word_of(gd, 0), 32'h80000000);
    chk("b64_2_w15", word_of(gd, 15), 32'h00000200);
    chk("b64_2_model", gd, exp_blk[1]);
    chk("b64_2_first", gf, 1'b0);
    chk("b64_2_last", gl, 1'b1);

    // Back-pressure: block held stable for 10 cycles
    send_word(32'h61000000, 1'b1, 2'd1);
    hd = blk_data;
    hf = blk_first;
    hl = blk_last;
    chk("stall_data_ref", hd, A_BLK);
    chk("stall_first_ref", hf, 1'b1);
    chk("stall_last_ref", hl, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", blk_valid, 1'b1);
      chk("stall_data", blk_data, hd);
      chk("stall_first", blk_first, hf);
      chk("stall_last", blk_last, hl);
      chk("stall_ready", in_ready, 1'b0);
    end
    get_blk(gd, gf, gl);
    chk("stall_hs_data", gd, A_BLK);
    chk("stall_ready_after", in_ready, 1'b1);

    // Reset mid-message discards the partial message
    for (int k = 0; k < 5; k++)
      send_word(32'h11111111, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", blk_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_data", blk_data, 512'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(32'h61626300, 1'b1, 2'd3);
    get_blk(gd, gf, gl);
    chk("midrst_abc_data", gd, ABC_BLK);
    chk("midrst_abc_first", gf, 1'b1);
    chk("midrst_abc_last", gl, 1'b1);
    @(posedge clk); #1;
    chk("midrst_no_extra", blk_valid, 1'b0);
    chk("midrst_ready_end", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
